// File: rtl/linear_retire_queue.sv
// In-order retire queue: accepts allocated local-buffer regions, issues each once,
// returns a free pulse per retirement and a blkdone pulse once every region has retired.
module linear_retire_queue #(
    parameter int unsigned LBW    = 16,
    parameter int unsigned N_ICFG = 4,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned ICFG_BW = $clog2(N_ICFG + 1),
    localparam int unsigned PBW     = $clog2(DEPTH),
    localparam int unsigned OBW     = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               linear_rdy,
    output logic               linear_ack,
    input  logic [LBW-1:0]     i_linear,
    input  logic [ICFG_BW-1:0] i_linear_id,
    output logic               issue_rdy,
    input  logic               issue_ack,
    output logic [LBW-1:0]     o_issue_linear,
    output logic [ICFG_BW-1:0] o_issue_id,
    output logic [PBW-1:0]     o_issue_slot,
    input  logic               retire_dval,
    output logic               free_dval,
    output logic [ICFG_BW-1:0] o_free_id,
    input  logic               blkend_dval,
    output logic               blkdone_dval,
    output logic [OBW-1:0]     o_occupancy
);

    localparam logic [OBW-1:0] FULL_OCC = OBW'(DEPTH);

    logic [LBW-1:0]     mem_lin_q [DEPTH];
    logic [LBW-1:0]     mem_lin_d [DEPTH];
    logic [ICFG_BW-1:0] mem_id_q  [DEPTH];
    logic [ICFG_BW-1:0] mem_id_d  [DEPTH];

    logic [PBW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PBW-1:0]     iss_ptr_q, iss_ptr_d;
    logic [PBW-1:0]     ret_ptr_q, ret_ptr_d;
    logic [OBW-1:0]     occ_q, occ_d;
    logic [OBW-1:0]     niss_q, niss_d;
    logic               pend_q, pend_d;
    logic               free_dval_q, free_dval_d;
    logic [ICFG_BW-1:0] free_id_q, free_id_d;
    logic               blkdone_q, blkdone_d;

    logic accept_fire;
    logic issue_fire;
    logic retire_fire;
    logic blk_req;

    always_comb begin
        accept_fire = linear_rdy && (occ_q != FULL_OCC) && !pend_q;
        issue_fire  = issue_ack && (occ_q > niss_q);
        retire_fire = retire_dval && (niss_q != '0);

        mem_lin_d = mem_lin_q;
        mem_id_d  = mem_id_q;
        wr_ptr_d  = wr_ptr_q;
        iss_ptr_d = iss_ptr_q;
        ret_ptr_d = ret_ptr_q;

        if (accept_fire) begin
            mem_lin_d[wr_ptr_q] = i_linear;
            mem_id_d[wr_ptr_q]  = i_linear_id;
            wr_ptr_d            = wr_ptr_q + PBW'(1);
        end
        if (issue_fire) begin
            iss_ptr_d = iss_ptr_q + PBW'(1);
        end
        if (retire_fire) begin
            ret_ptr_d = ret_ptr_q + PBW'(1);
        end

        occ_d  = occ_q + OBW'(accept_fire) - OBW'(retire_fire);
        niss_d = niss_q + OBW'(issue_fire) - OBW'(retire_fire);

        free_dval_d = retire_fire;
        free_id_d   = retire_fire ? mem_id_q[ret_ptr_q] : free_id_q;

        // A block end raised while one is already pending simply merges into it.
        blk_req   = pend_q || blkend_dval;
        blkdone_d = blk_req && (occ_d == '0);
        pend_d    = blk_req && (occ_d != '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_lin_q[i] <= '0;
                mem_id_q[i]  <= '0;
            end
            wr_ptr_q    <= '0;
            iss_ptr_q   <= '0;
            ret_ptr_q   <= '0;
            occ_q       <= '0;
            niss_q      <= '0;
            pend_q      <= 1'b0;
            free_dval_q <= 1'b0;
            free_id_q   <= '0;
            blkdone_q   <= 1'b0;
        end else begin
            mem_lin_q   <= mem_lin_d;
            mem_id_q    <= mem_id_d;
            wr_ptr_q    <= wr_ptr_d;
            iss_ptr_q   <= iss_ptr_d;
            ret_ptr_q   <= ret_ptr_d;
            occ_q       <= occ_d;
            niss_q      <= niss_d;
            pend_q      <= pend_d;
            free_dval_q <= free_dval_d;
            free_id_q   <= free_id_d;
            blkdone_q   <= blkdone_d;
        end
    end

    assign linear_ack     = accept_fire;
    assign issue_rdy      = occ_q > niss_q;
    assign o_issue_linear = mem_lin_q[iss_ptr_q];
    assign o_issue_id     = mem_id_q[iss_ptr_q];
    assign o_issue_slot   = iss_ptr_q;
    assign free_dval      = free_dval_q;
    assign o_free_id      = free_id_q;
    assign blkdone_dval   = blkdone_q;
    assign o_occupancy    = occ_q;

endmodule

// File: tb/tb_linear_retire_queue.sv
// Directed and random stimulus for linear_retire_queue, checked against a queue-based
// reference model of live regions.
module tb_linear_retire_queue;

    localparam int unsigned LBW     = 16;
    localparam int unsigned N_ICFG  = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ICFG_BW = $clog2(N_ICFG + 1);
    localparam int unsigned PBW     = $clog2(DEPTH);
    localparam int unsigned OBW     = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               linear_rdy = 1'b0;
    logic               linear_ack;
    logic [LBW-1:0]     i_linear = '0;
    logic [ICFG_BW-1:0] i_linear_id = '0;
    logic               issue_rdy;
    logic               issue_ack = 1'b0;
    logic [LBW-1:0]     o_issue_linear;
    logic [ICFG_BW-1:0] o_issue_id;
    logic [PBW-1:0]     o_issue_slot;
    logic               retire_dval = 1'b0;
    logic               free_dval;
    logic [ICFG_BW-1:0] o_free_id;
    logic               blkend_dval = 1'b0;
    logic               blkdone_dval;
    logic [OBW-1:0]     o_occupancy;

    linear_retire_queue #(.LBW(LBW), .N_ICFG(N_ICFG), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst),
        .linear_rdy(linear_rdy), .linear_ack(linear_ack),
        .i_linear(i_linear), .i_linear_id(i_linear_id),
        .issue_rdy(issue_rdy), .issue_ack(issue_ack),
        .o_issue_linear(o_issue_linear), .o_issue_id(o_issue_id), .o_issue_slot(o_issue_slot),
        .retire_dval(retire_dval), .free_dval(free_dval), .o_free_id(o_free_id),
        .blkend_dval(blkend_dval), .blkdone_dval(blkdone_dval), .o_occupancy(o_occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LBW-1:0]     lin;
        logic [ICFG_BW-1:0] id;
    } ent_t;

    ent_t               live[$];
    int                 n_iss;
    int unsigned        iss_cnt;
    bit                 pend;
    bit                 m_free;
    logic [ICFG_BW-1:0] m_free_id;
    bit                 m_blk;
    bit                 mem_zero;
    int                 total = 0;
    int                 bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        live.delete();
        n_iss    = 0;
        iss_cnt  = 0;
        pend     = 1'b0;
        m_free   = 1'b0;
        m_free_id = '0;
        m_blk    = 1'b0;
        mem_zero = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        linear_rdy = 1'b0; issue_ack = 1'b0; retire_dval = 1'b0; blkend_dval = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_ack", 32'(linear_ack), 32'd0);
        chk("rst_issue_rdy", 32'(issue_rdy), 32'd0);
        chk("rst_issue_lin", 32'(o_issue_linear), 32'd0);
        chk("rst_issue_id", 32'(o_issue_id), 32'd0);
        chk("rst_issue_slot", 32'(o_issue_slot), 32'd0);
        chk("rst_free", 32'(free_dval), 32'd0);
        chk("rst_free_id", 32'(o_free_id), 32'd0);
        chk("rst_blkdone", 32'(blkdone_dval), 32'd0);
        chk("rst_occ", 32'(o_occupancy), 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input bit rdy, input logic [LBW-1:0] lin, input logic [ICFG_BW-1:0] id,
                        input bit iack, input bit ret, input bit blk);
        bit   exp_ack, exp_irdy, iv, rv, breq;
        ent_t e;
        @(negedge clk);
        linear_rdy = rdy; i_linear = lin; i_linear_id = id;
        issue_ack = iack; retire_dval = ret; blkend_dval = blk;
        #1;
        exp_ack  = rdy && (live.size() < DEPTH) && !pend;
        exp_irdy = live.size() > n_iss;
        chk("linear_ack", 32'(linear_ack), 32'(exp_ack));
        chk("issue_rdy", 32'(issue_rdy), 32'(exp_irdy));
        if (exp_irdy) begin
            chk("issue_lin", 32'(o_issue_linear), 32'(live[n_iss].lin));
            chk("issue_id", 32'(o_issue_id), 32'(live[n_iss].id));
        end else if (mem_zero) begin
            chk("issue_lin0", 32'(o_issue_linear), 32'd0);
            chk("issue_id0", 32'(o_issue_id), 32'd0);
        end
        chk("issue_slot", 32'(o_issue_slot), iss_cnt % DEPTH);
        chk("occupancy", 32'(o_occupancy), 32'(live.size()));
        chk("free_dval", 32'(free_dval), 32'(m_free));
        if (m_free) chk("free_id", 32'(o_free_id), 32'(m_free_id));
        chk("blkdone", 32'(blkdone_dval), 32'(m_blk));

        iv = iack && exp_irdy;
        rv = ret && (n_iss > 0);
        @(posedge clk);
        m_free = rv;
        if (rv) begin
            m_free_id = live[0].id;
            void'(live.pop_front());
        end
        if (exp_ack) begin
            e.lin = lin; e.id = id;
            live.push_back(e);
            mem_zero = 1'b0;
        end
        if (iv) iss_cnt++;
        n_iss = n_iss + int'(iv) - int'(rv);
        breq = pend || blk;
        if (breq && live.size() == 0) begin
            m_blk = 1'b1; pend = 1'b0;
        end else begin
            m_blk = 1'b0; pend = breq;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && live.size() != 0; i++) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_clear();
        do_reset();

        // single region
        step(1'b1, 16'h0010, 3'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // fill, full, ignored retire, resume
        for (int i = 0; i < 4; i++) step(1'b1, LBW'($urandom), ICFG_BW'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0bad, 3'd4, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0bad, 3'd4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0bad, 3'd4, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0123, 3'd2, 1'b0, 1'b0, 1'b0);
        drain();

        // full-rate streaming with pointer wrap
        for (int i = 0; i < 12; i++)
            step(1'b1, LBW'($urandom), ICFG_BW'(i % (N_ICFG + 1)), 1'b1, 1'b1, 1'b0);
        drain();

        // accept + issue + retire together with occ=2, niss=1
        step(1'b1, 16'h0a00, 3'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0a01, 3'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0a02, 3'd4, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drain();

        // block end with live entries, then with an empty queue
        step(1'b1, 16'h0b00, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0b01, 3'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0b02, 3'd2, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h0b03, 3'd2, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'h0b04, 3'd2, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0b05, 3'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0b06, 3'd3, 1'b0, 1'b0, 1'b0);
        drain();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // reset with live entries and a free pulse in flight
        step(1'b1, 16'h0c00, 3'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0c01, 3'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0c02, 3'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0c03, 3'd4, 1'b0, 1'b1, 1'b0);
        do_reset();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0d00, 3'd3, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) < 6), LBW'($urandom), ICFG_BW'($urandom_range(0, N_ICFG)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 19) == 0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
